fan32_ctrl_seq: RTL and testbench

//  Control sequencer for the 32-input flexible adder network (fan32).
//  - Queues reduction configurations (adder enables + level 2/3/4 mux selects), each with a beat count.
//  - Admits data beats under a valid/ready handshake.
//  - Skews each config through a per-level pipeline, so every network level sees the config of the beat it currently holds.
//  - Flags beats emerging at the network output.

---
 rtl/fan32_ctrl_seq.sv | 184 ++++++++++++++++++
 tb/tb_fan32_ctrl_seq.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fan32_ctrl_seq.sv
// fan32_ctrl_seq: config FIFO, beat counter and per-level skew chain that steer the fan32 adder network.
// Define FAN_MUX_CHECK_EN to reject configs whose mux-select groups are not zero- or one-hot.
module fan32_ctrl_seq #(
  parameter int CFG_DEPTH = 4,
  parameter int CNT_W     = 16,
  parameter int LVL_LAT   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [30:0]      cfg_adder,
  input  logic [15:0]      cfg_mux2,
  input  logic [11:0]      cfg_mux3,
  input  logic [7:0]       cfg_mux4,
  input  logic [CNT_W-1:0] cfg_beats,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [30:0]      ctrl_adder,
  output logic [15:0]      ctrl_2_mux,
  output logic [11:0]      ctrl_3_mux,
  output logic [7:0]       ctrl_4_mux,
  output logic             out_valid,
  output logic             out_last,
  output logic             busy,
  output logic             cfg_err
);
  localparam int PTR_W  = $clog2(CFG_DEPTH);
  localparam int CHAIN  = 4 * LVL_LAT;
  localparam int VCHAIN = 5 * LVL_LAT;

  // Adder i sits on level L where i has exactly L trailing ones (i==15 is the root).
  localparam logic [30:0] L0_MASK = 31'h5555_5555;
  localparam logic [30:0] L1_MASK = 31'h2222_2222;
  localparam logic [30:0] L2_MASK = 31'h0808_0808;
  localparam logic [30:0] L3_MASK = 31'h0080_0080;
  localparam logic [30:0] L4_MASK = 31'h0000_8000;

  typedef struct packed {
    logic [30:0] adder;
    logic [15:0] mux2;
    logic [11:0] mux3;
    logic [7:0]  mux4;
  } cfg_t;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  cfg_t             r_mem   [CFG_DEPTH];
  logic [CNT_W-1:0] r_beats [CFG_DEPTH];
  logic [PTR_W:0]   r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_cnt;
  cfg_t             r_chain_cfg [1:CHAIN];
  logic [VCHAIN:1]  r_chain_v, r_chain_last;
  state_t           r_state, w_state_nxt;

  logic             w_empty, w_full, w_push, w_fire, w_last, w_cfg_bad;
  cfg_t             w_head, w_in_cfg;
  logic [CNT_W-1:0] w_head_beats;

  assign w_empty      = (r_wr_ptr == r_rd_ptr);
  assign w_full       = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                        (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign w_in_cfg     = {cfg_adder, cfg_mux2, cfg_mux3, cfg_mux4};
  assign w_head       = r_mem[r_rd_ptr[PTR_W-1:0]];
  assign w_head_beats = r_beats[r_rd_ptr[PTR_W-1:0]];
  assign w_fire       = in_valid & ~w_empty;
  assign w_last       = (w_head_beats == '0) || (r_cnt == w_head_beats - 1'b1);
  assign w_push       = cfg_valid & ~w_full & ~w_cfg_bad;

  assign cfg_ready = ~w_full;
  assign in_ready  = ~w_empty;
  assign busy      = (r_state != S_IDLE);

`ifdef FAN_MUX_CHECK_EN
  function automatic logic mux_bad(input logic [15:0] m2, input logic [11:0] m3,
                                   input logic [7:0] m4);
    logic bad;
    bad = 1'b0;
    for (int g = 0; g < 8; g++) if (m2[2*g +: 2] == 2'b11) bad = 1'b1;
    for (int g = 0; g < 4; g++) if ($countones(m3[3*g +: 3]) > 1) bad = 1'b1;
    for (int g = 0; g < 2; g++) if ($countones(m4[4*g +: 4]) > 1) bad = 1'b1;
    return bad;
  endfunction

  logic r_cfg_err;
  assign w_cfg_bad = mux_bad(cfg_mux2, cfg_mux3, cfg_mux4);
  assign cfg_err   = r_cfg_err;

  // Offending configs still complete their handshake so the producer never stalls on them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  r_cfg_err <= 1'b0;
    else if (cfg_valid && !w_full && w_cfg_bad)  r_cfg_err <= 1'b1;
  end
`else
  assign w_cfg_bad = 1'b0;
  assign cfg_err   = 1'b0;
`endif

  // NOTE: FIFO storage has no reset; an entry is only read after the write pointer has covered it.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[PTR_W-1:0]]   <= w_in_cfg;
      r_beats[r_wr_ptr[PTR_W-1:0]] <= cfg_beats;
    end
  end

  // NOTE: all clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_fire) begin
        if (w_last) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
          r_cnt    <= '0;
        end else begin
          r_cnt    <= r_cnt + 1'b1;
        end
      end
    end
  end

  // Valid/last flags run one level past the config so out_valid marks the network output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chain_v    <= '0;
      r_chain_last <= '0;
    end else begin
      r_chain_v    <= {r_chain_v[VCHAIN-1:1], w_fire};
      r_chain_last <= {r_chain_last[VCHAIN-1:1], w_fire & w_last};
    end
  end

  always_ff @(posedge clk) begin
    r_chain_cfg[1] <= w_head;
    for (int s = 2; s <= CHAIN; s++) r_chain_cfg[s] <= r_chain_cfg[s-1];
  end

  // NOTE: every output gets a default first, so no path through this block can infer a latch.
  always_comb begin
    ctrl_adder = w_fire ? (w_head.adder & L0_MASK) : '0;
    ctrl_2_mux = '0;
    ctrl_3_mux = '0;
    ctrl_4_mux = '0;
    if (r_chain_v[LVL_LAT])
      ctrl_adder = ctrl_adder | (r_chain_cfg[LVL_LAT].adder & L1_MASK);
    if (r_chain_v[2*LVL_LAT]) begin
      ctrl_adder = ctrl_adder | (r_chain_cfg[2*LVL_LAT].adder & L2_MASK);
      ctrl_2_mux = r_chain_cfg[2*LVL_LAT].mux2;
    end
    if (r_chain_v[3*LVL_LAT]) begin
      ctrl_adder = ctrl_adder | (r_chain_cfg[3*LVL_LAT].adder & L3_MASK);
      ctrl_3_mux = r_chain_cfg[3*LVL_LAT].mux3;
    end
    if (r_chain_v[4*LVL_LAT]) begin
      ctrl_adder = ctrl_adder | (r_chain_cfg[4*LVL_LAT].adder & L4_MASK);
      ctrl_4_mux = r_chain_cfg[4*LVL_LAT].mux4;
    end
  end

  assign out_valid = r_chain_v[VCHAIN];
  assign out_last  = r_chain_v[VCHAIN] & r_chain_last[VCHAIN];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (!w_empty) w_state_nxt = S_RUN;
      S_RUN:   if (w_empty)  w_state_nxt = (|r_chain_v) ? S_DRAIN : S_IDLE;
      S_DRAIN: begin
        if (!w_empty)         w_state_nxt = S_RUN;
        else if (~|r_chain_v) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_fan32_ctrl_seq.sv
// Self-checking bench for fan32_ctrl_seq: a cycle-history reference model compared every cycle,
// plus directed scenarios with hand-computed literals. Honours FAN_MUX_CHECK_EN when defined.
module tb_fan32_ctrl_seq;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_valid, cfg_ready, in_valid, in_ready;
  logic [30:0] cfg_adder, ctrl_adder;
  logic [15:0] cfg_mux2, ctrl_2_mux, cfg_beats;
  logic [11:0] cfg_mux3, ctrl_3_mux;
  logic [7:0]  cfg_mux4, ctrl_4_mux;
  logic        out_valid, out_last, busy, cfg_err;

  fan32_ctrl_seq dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_adder(cfg_adder), .cfg_mux2(cfg_mux2), .cfg_mux3(cfg_mux3), .cfg_mux4(cfg_mux4),
    .cfg_beats(cfg_beats), .in_valid(in_valid), .in_ready(in_ready),
    .ctrl_adder(ctrl_adder), .ctrl_2_mux(ctrl_2_mux), .ctrl_3_mux(ctrl_3_mux),
    .ctrl_4_mux(ctrl_4_mux), .out_valid(out_valid), .out_last(out_last),
    .busy(busy), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    bit [30:0] adder;
    bit [15:0] mux2;
    bit [11:0] mux3;
    bit [7:0]  mux4;
    bit [15:0] beats;
  } mcfg_t;

  typedef struct packed {
    bit    v;
    bit    last;
    mcfg_t c;
  } mbeat_t;

  mcfg_t       m_q[$];
  mbeat_t      m_hist[8];     // beat accepted in cycle n lives at m_hist[n % 8]
  int unsigned m_cyc = 0;
  int          m_cnt, m_sz;
  bit          m_busy, m_err, m_chain, m_drop;
  mbeat_t      m_nb;
  mcfg_t       m_new;

  function automatic int lvl_of(input int i);
    if (i % 2 == 0)  return 0;
    if (i % 4 == 1)  return 1;
    if (i % 8 == 3)  return 2;
    if (i % 16 == 7) return 3;
    return 4;
  endfunction

  function automatic logic [30:0] lvl_mask(input int k);
    logic [30:0] m;
    m = '0;
    for (int i = 0; i < 31; i++) if (lvl_of(i) == k) m[i] = 1'b1;
    return m;
  endfunction

`ifdef FAN_MUX_CHECK_EN
  function automatic bit cfg_bad(input logic [15:0] m2, input logic [11:0] m3, input logic [7:0] m4);
    bit bad;
    bad = 1'b0;
    for (int g = 0; g < 8; g++) if ($countones(m2[2*g +: 2]) > 1) bad = 1'b1;
    for (int g = 0; g < 4; g++) if ($countones(m3[3*g +: 3]) > 1) bad = 1'b1;
    for (int g = 0; g < 2; g++) if ($countones(m4[4*g +: 4]) > 1) bad = 1'b1;
    return bad;
  endfunction
`endif

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_cnt  = 0;
      m_busy = 1'b0;
      m_err  = 1'b0;
      for (int i = 0; i < 8; i++) m_hist[i] = '0;
    end else begin
      m_sz    = m_q.size();
      m_chain = 1'b0;
      for (int j = 1; j <= 5; j++) if (m_hist[3'(m_cyc - j)].v) m_chain = 1'b1;
      m_nb = '0;
      if (in_valid && m_sz != 0) begin
        m_nb.v = 1'b1;
        m_nb.c = m_q[0];
        m_cnt++;
        if (m_cnt >= ((m_q[0].beats == 0) ? 1 : int'(m_q[0].beats))) begin
          m_nb.last = 1'b1;
          m_cnt     = 0;
          void'(m_q.pop_front());
        end
      end
      if (cfg_valid && m_sz < 4) begin
        m_drop = 1'b0;
`ifdef FAN_MUX_CHECK_EN
        m_drop = cfg_bad(cfg_mux2, cfg_mux3, cfg_mux4);
`endif
        m_new = {cfg_adder, cfg_mux2, cfg_mux3, cfg_mux4, cfg_beats};
        if (m_drop) m_err = 1'b1;
        else        m_q.push_back(m_new);
      end
      m_hist[3'(m_cyc)] = m_nb;
      m_cyc++;
      m_busy = (m_sz != 0) || m_chain;
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [30:0] e_adder;
  logic [15:0] e_m2;
  logic [11:0] e_m3;
  logic [7:0]  e_m4;
  mbeat_t      e_b;

  always @(negedge clk) begin
    if (rst_n) begin
      e_adder = (in_valid && m_q.size() != 0) ? (m_q[0].adder & lvl_mask(0)) : '0;
      e_m2 = '0; e_m3 = '0; e_m4 = '0;
      for (int k = 1; k <= 4; k++) begin
        e_b = m_hist[3'(m_cyc - k)];
        if (e_b.v) begin
          e_adder = e_adder | (e_b.c.adder & lvl_mask(k));
          if (k == 2) e_m2 = e_b.c.mux2;
          if (k == 3) e_m3 = e_b.c.mux3;
          if (k == 4) e_m4 = e_b.c.mux4;
        end
      end
      e_b = m_hist[3'(m_cyc - 5)];
      check("cyc_ctrl_adder", 32'(ctrl_adder), 32'(e_adder));
      check("cyc_ctrl_2_mux", 32'(ctrl_2_mux), 32'(e_m2));
      check("cyc_ctrl_3_mux", 32'(ctrl_3_mux), 32'(e_m3));
      check("cyc_ctrl_4_mux", 32'(ctrl_4_mux), 32'(e_m4));
      check("cyc_out_valid",  32'(out_valid),  32'(e_b.v));
      check("cyc_out_last",   32'(out_last),   32'(e_b.v & e_b.last));
      check("cyc_in_ready",   32'(in_ready),   32'(m_q.size() != 0));
      check("cyc_cfg_ready",  32'(cfg_ready),  32'(m_q.size() < 4));
      check("cyc_busy",       32'(busy),       32'(m_busy));
      check("cyc_cfg_err",    32'(cfg_err),    32'(m_err));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cfg_valid = 1'b0; in_valid = 1'b0; cfg_adder = '0;
    cfg_mux2 = '0; cfg_mux3 = '0; cfg_mux4 = '0; cfg_beats = '0;
  endtask

  task automatic drive_cfg(input logic [30:0] a, input logic [15:0] m2, input logic [11:0] m3,
                           input logic [7:0] m4, input logic [15:0] b);
    cfg_valid = 1'b1; cfg_adder = a; cfg_mux2 = m2; cfg_mux3 = m3; cfg_mux4 = m4; cfg_beats = b;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    cfg_valid = 1'b0;
    in_valid  = 1'b1;
    while (busy && k < 60) begin
      tick();
      k++;
    end
    in_valid = 1'b0;
    #2;
    check(name, 32'(busy), 0);
  endtask

  logic [15:0] v_a, v_b, v_c, v_d;
  logic [30:0] e5 [1:9];

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #2;
    check("rst_ctrl_adder", 32'(ctrl_adder), 0);
    check("rst_ctrl_muxes", 32'({ctrl_2_mux, ctrl_3_mux, ctrl_4_mux}), 0);
    check("rst_out_valid",  32'(out_valid), 0);
    check("rst_in_ready",   32'(in_ready), 0);
    check("rst_busy",       32'(busy), 0);
    check("rst_cfg_ready",  32'(cfg_ready), 1);
    check("rst_cfg_err",    32'(cfg_err), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // One config, three beats.
    tick();
    drive_cfg(31'h7FFF_FFFF, 16'hAAAA, 12'h924, 8'h88, 16'd3);
    in_valid = 1'b1;
    #2;
    check("t2_in_ready_c", 32'(in_ready), 0);
    v_a = 16'h000E; v_b = 16'h00E0; v_c = 16'h01C0; v_d = 16'h0100;
    for (int j = 1; j <= 9; j++) begin
      tick();
      cfg_valid = 1'b0;
      #2;
      check("t2_in_ready", 32'(in_ready), 32'(v_a[j]));
      check("t2_even_bits", 32'(ctrl_adder & 31'h5555_5555), v_a[j] ? 32'h5555_5555 : 0);
      check("t2_bit15", 32'(ctrl_adder[15]), 32'(v_b[j]));
      check("t2_out_valid", 32'(out_valid), 32'(v_c[j]));
      check("t2_out_last", 32'(out_last), 32'(v_d[j]));
      if (j == 2) check("t2_adder_c2", 32'(ctrl_adder), 32'h7777_7777);
      if (j == 5) check("t2_adder_c5", 32'(ctrl_adder), 32'h0888_8888);
      if (j == 6) check("t2_mux4_c6", 32'(ctrl_4_mux), 32'h88);
    end
    drain("t2_idle");

    // Back-to-back configs A then B.
    tick();
    drive_cfg(31'h0000_0001, 16'h0, 12'h0, 8'h01, 16'd2);
    in_valid = 1'b1;
    v_a = 16'h0006; v_b = 16'h0018; v_c = 16'h03C0; v_d = 16'h0280;
    for (int j = 1; j <= 10; j++) begin
      tick();
      if (j == 1) drive_cfg(31'h4000_0000, 16'h0, 12'h0, 8'h10, 16'd2);
      else        cfg_valid = 1'b0;
      #2;
      check("t3_bit0", 32'(ctrl_adder[0]), 32'(v_a[j]));
      check("t3_bit30", 32'(ctrl_adder[30]), 32'(v_b[j]));
      check("t3_mux4", 32'(ctrl_4_mux), (j == 5 || j == 6) ? 32'h01 : (j == 7 || j == 8) ? 32'h10 : 0);
      check("t3_out_valid", 32'(out_valid), 32'(v_c[j]));
      check("t3_out_last", 32'(out_last), 32'(v_d[j]));
    end
    drain("t3_idle");

    // FIFO full, fifth config waits for a pop.
    for (int i = 0; i < 4; i++) begin
      tick();
      drive_cfg(31'(1 << (2 * i)), 16'h0, 12'h0, 8'h0, (i == 0) ? 16'd2 : 16'd1);
      #2;
      check("t4_ready_fill", 32'(cfg_ready), 1);
    end
    tick();
    drive_cfg(31'h0000_0100, 16'h0, 12'h0, 8'h0, 16'd0);
    in_valid = 1'b1;
    #2;
    check("t4_ready_full", 32'(cfg_ready), 0);
    tick();
    #2;
    check("t4_ready_pop", 32'(cfg_ready), 0);
    tick();
    #2;
    check("t4_ready_free", 32'(cfg_ready), 1);
    check("t4_in_ready", 32'(in_ready), 1);
    drain("t4_idle");

    // Bubbles: in_valid 1,0,1.
    e5 = '{31'h5555_5555, 31'h2222_2222, 31'h5D5D_5D5D, 31'h22A2_22A2, 31'h0808_8808,
           31'h0080_0080, 31'h0000_8000, 31'h0, 31'h0};
    v_c = 16'h0140;
    tick();
    drive_cfg(31'h7FFF_FFFF, 16'hAAAA, 12'h924, 8'h88, 16'd2);
    in_valid = 1'b0;
    for (int j = 1; j <= 9; j++) begin
      tick();
      cfg_valid = 1'b0;
      in_valid  = (j == 1 || j == 3);
      #2;
      check("t5_adder", 32'(ctrl_adder), 32'(e5[j]));
      check("t5_out_valid", 32'(out_valid), 32'(v_c[j]));
    end
    drain("t5_idle");

    // Reset in the middle of a run.
    tick();
    drive_cfg(31'h7FFF_FFFF, 16'h5555, 12'h249, 8'h11, 16'd5);
    in_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    repeat (3) tick();
    #1;
    check("t6_busy_before", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_adder", 32'(ctrl_adder), 0);
    check("t6_rst_mux4", 32'(ctrl_4_mux), 0);
    check("t6_rst_out_valid", 32'(out_valid), 0);
    check("t6_rst_busy", 32'(busy), 0);
    check("t6_rst_in_ready", 32'(in_ready), 0);
    check("t6_rst_cfg_ready", 32'(cfg_ready), 1);
    idle_inputs();
    tick();
    rst_n = 1'b1;

    // Config with overlapping level-2 selects.
    tick();
    drive_cfg(31'h0000_0003, 16'hC000, 12'h0, 8'h0, 16'd1);
    in_valid = 1'b1;
    #2;
    check("t6_err_cfg_ready", 32'(cfg_ready), 1);
    tick();
    cfg_valid = 1'b0;
`ifdef FAN_MUX_CHECK_EN
    for (int j = 1; j <= 3; j++) begin
      #2;
      check("t6_err_in_ready", 32'(in_ready), 0);
      check("t6_err_flag", 32'(cfg_err), 1);
      tick();
    end
    rst_n = 1'b0;
    #2;
    check("t6_err_cleared", 32'(cfg_err), 0);
    idle_inputs();
    tick();
    rst_n = 1'b1;
`else
    #2;
    check("t6_noerr_in_ready", 32'(in_ready), 1);
    check("t6_noerr_flag", 32'(cfg_err), 0);
    drain("t6_idle");
`endif

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected a finished run");
    $fatal(1, "watchdog expired");
  end
endmodule
